// File: rtl/dii_package.sv
// Shared DII flit type used by debug-interconnect sources, routers and arbiters.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_dii_arbiter_pkg.sv
// Types and helpers for the packet-level round-robin DII arbiter.
package osd_dii_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned IDX_W     = 4;

  // First valid index found when scanning ptr, ptr+1, ... modulo ports.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] valid,
                                               input logic [IDX_W-1:0]     ptr,
                                               input int unsigned          ports);
    logic [IDX_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      idx = (32'(ptr) + i) % ports;
      if (!found && (i < ports) && valid[idx[IDX_W-1:0]]) begin
        win   = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/osd_dii_skid_buffer.sv
// Two-entry valid/ready register stage for DII flit streams.
// Entry 0 drives the output; entry 1 absorbs one flit while the sink stalls.
module osd_dii_skid_buffer
  import dii_package::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  dii_flit i_flit,
  output logic    o_ready,
  output dii_flit o_flit,
  input  logic    i_ready,
  output logic    o_busy
);

  logic [1:0] r_count;
  dii_flit    r_e0;
  dii_flit    r_e1;
  logic       w_push;
  logic       w_pop;

  // Handshakes and output view of the head entry.
  always_comb begin
    o_ready      = (r_count != 2'd2);
    o_busy       = (r_count != 2'd0);
    o_flit.valid = (r_count != 2'd0);
    o_flit.last  = r_e0.last;
    o_flit.data  = r_e0.data;
    w_push       = i_flit.valid & o_ready;
    w_pop        = o_flit.valid & i_ready;
  end

  // Occupancy and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_e0    <= i_flit;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_push, w_pop})
            2'b11:   r_e0 <= i_flit;
            2'b10: begin
              r_e1    <= i_flit;
              r_count <= 2'd2;
            end
            2'b01:   r_count <= 2'd0;
            default: r_count <= 2'd1;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_e0    <= r_e1;
            r_count <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/osd_dii_arbiter.sv
// Packet-level round-robin arbiter merging PORTS DII streams onto one output.
// A granted source owns the output until its last flit is accepted.
// Optional build macro OSD_DII_ARBITER_STATS_EN adds per-port packet counters.
module osd_dii_arbiter
  import osd_dii_arbiter_pkg::*;
  import dii_package::*;
#(
  parameter int unsigned PORTS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  dii_flit          in_flit [PORTS],
  output logic [PORTS-1:0] in_ready,
  output dii_flit          out_flit,
  input  logic             out_ready,
  output logic             busy
`ifdef OSD_DII_ARBITER_STATS_EN
  ,
  output logic [15:0]      pkt_count [PORTS]
`endif
);

  localparam int unsigned PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [PTR_W-1:0]     r_owner;
  logic [PTR_W-1:0]     w_owner_nxt;
  logic [PTR_W-1:0]     w_sel;
  logic [MAX_PORTS-1:0] w_valid;
  logic                 w_space;
  logic                 w_grant_en;
  logic                 w_accept;
  logic                 w_skid_busy;
  dii_flit              w_sel_flit;
  dii_flit              w_skid_in;

  // Zero-padded request vector for the round-robin scan.
  for (genvar g = 0; g < MAX_PORTS; g++) begin : g_valid
    if (g < PORTS) begin : g_used
      assign w_valid[g] = in_flit[g].valid;
    end else begin : g_pad
      assign w_valid[g] = 1'b0;
    end
  end

  // Arbiter state, pointer and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Grant selection, per-port ready and next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    in_ready    = '0;

    if (r_state == ARB_LOCKED) begin
      w_sel = r_owner;
    end else begin
      w_sel = PTR_W'(rr_pick(w_valid, IDX_W'(r_ptr), PORTS));
    end
    w_sel_flit = in_flit[w_sel];

    // Ready is held low during reset so no flit is taken before the FSM runs.
    w_grant_en = rst_n & w_space & ((r_state == ARB_LOCKED) | (|w_valid));
    w_accept   = w_grant_en & w_sel_flit.valid;
    if (w_grant_en) begin
      in_ready[w_sel] = 1'b1;
    end

    if (w_accept) begin
      if (w_sel_flit.last) begin
        w_state_nxt = ARB_IDLE;
        w_ptr_nxt   = (w_sel == PTR_W'(PORTS - 1)) ? '0 : w_sel + PTR_W'(1);
      end else begin
        w_state_nxt = ARB_LOCKED;
        w_owner_nxt = w_sel;
      end
    end

    w_skid_in.valid = w_accept;
    w_skid_in.last  = w_sel_flit.last;
    w_skid_in.data  = w_sel_flit.data;
    busy            = (r_state == ARB_LOCKED) | w_skid_busy;
  end

  osd_dii_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flit  (w_skid_in),
    .o_ready (w_space),
    .o_flit  (out_flit),
    .i_ready (out_ready),
    .o_busy  (w_skid_busy)
  );

`ifdef OSD_DII_ARBITER_STATS_EN
  logic [15:0] r_pkt_count [PORTS];

  // Count completed packets per source; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        r_pkt_count[i] <= '0;
      end
    end else if (w_accept && w_sel_flit.last) begin
      r_pkt_count[w_sel] <= r_pkt_count[w_sel] + 16'd1;
    end
  end

  assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_osd_dii_arbiter.sv
// Randomized bench for osd_dii_arbiter (PORTS=3) against a transaction-level model.
module tb_osd_dii_arbiter;
  import dii_package::*;

  localparam int unsigned PORTS = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  dii_flit          in_flit [PORTS];
  logic [PORTS-1:0] in_ready;
  dii_flit          out_flit;
  logic             out_ready;
  logic             busy;
`ifdef OSD_DII_ARBITER_STATS_EN
  logic [15:0]      pkt_count [PORTS];
`endif

  always #5 clk = ~clk;

  osd_dii_arbiter #(.PORTS(PORTS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef OSD_DII_ARBITER_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source generators: remaining flits of the current packet and next payload.
  int          src_rem  [PORTS];
  logic [15:0] src_data [PORTS];
  int          max_len;
  int          p_valid;
  int          p_ready;
  bit          rot_mode;
  int          rot_prev;

  // Reference model: flits accepted but not yet delivered, and packet ownership.
  logic [16:0] m_q [$];
  bit          m_locked;
  int          m_owner;
  int          m_ptr;
  logic [15:0] m_cnt [PORTS];

  task automatic new_payload(input int s);
    src_data[s] = {4'(s), 12'($urandom)};
  endtask

  task automatic new_packet(input int s);
    src_rem[s] = $urandom_range(max_len, 1);
    new_payload(s);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    for (int s = 0; s < PORTS; s++) begin
      m_cnt[s] = '0;
      new_packet(s);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_flit.valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One clock: drive at negedge, predict and compare, then commit the edge to the model.
  task automatic step();
    logic [PORTS-1:0] exp_rdy;
    int               gnt;
    int               idx;
    bit               found;
    @(negedge clk);
    for (int s = 0; s < PORTS; s++) begin
      in_flit[s].valid = ($urandom_range(99, 0) < p_valid);
      in_flit[s].last  = (src_rem[s] == 1);
      in_flit[s].data  = src_data[s];
    end
    out_ready = ($urandom_range(99, 0) < p_ready);
    #1;
    exp_rdy = '0;
    gnt     = -1;
    if (m_q.size() < 2) begin
      if (m_locked) begin
        gnt = m_owner;
      end else begin
        found = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
          idx = (m_ptr + k) % PORTS;
          if (!found && in_flit[idx].valid) begin
            gnt   = idx;
            found = 1'b1;
          end
        end
      end
      if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_flit.valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_flit", 32'({out_flit.last, out_flit.data}), 32'(m_q[0]));
    check("busy", 32'(busy), 32'(m_locked || (m_q.size() != 0)));
    if (rot_mode) begin
      check("rot_valid", 32'(out_flit.valid), 32'd1);
      if (rot_prev >= 0) check("rot_order", 32'(out_flit.data[15:12]), 32'((rot_prev + 1) % PORTS));
      rot_prev = int'(out_flit.data[15:12]);
    end
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (gnt >= 0 && in_flit[gnt].valid) begin
      m_q.push_back({in_flit[gnt].last, in_flit[gnt].data});
      if (in_flit[gnt].last) begin
        m_locked   = 1'b0;
        m_ptr      = (gnt + 1) % PORTS;
        m_cnt[gnt] = m_cnt[gnt] + 16'd1;
        new_packet(gnt);
      end else begin
        m_locked     = 1'b1;
        m_owner      = gnt;
        src_rem[gnt] = src_rem[gnt] - 1;
        new_payload(gnt);
      end
    end
  endtask

  task automatic drop_valids();
    for (int s = 0; s < PORTS; s++) in_flit[s].valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    max_len   = 1;
    p_valid   = 100;
    p_ready   = 100;
    rot_mode  = 1'b0;
    rot_prev  = -1;
    model_reset();
    for (int s = 0; s < PORTS; s++) begin
      in_flit[s].valid = 1'b1;
      in_flit[s].last  = 1'b1;
      in_flit[s].data  = src_data[s];
    end
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");
    drop_valids();
    rst_n = 1'b1;

    // Continuous single-flit packets from every source: strict rotation at full rate.
    repeat (2) step();
    rot_mode = 1'b1;
    repeat (200) step();
    rot_mode = 1'b0;

    // Multi-flit packets with source gaps and random backpressure.
    max_len = 5;
    p_valid = 70;
    p_ready = 60;
    repeat (500) step();

    // Reset in the middle of traffic drops any partial packet.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    model_reset();
    drop_valids();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) step();

    // Heavy backpressure keeps the skid full most of the time.
    p_valid = 90;
    p_ready = 20;
    repeat (400) step();

    // Drain.
    p_valid = 0;
    p_ready = 100;
    repeat (12) step();
    check("drained", 32'(m_q.size()), 32'd0);

`ifdef OSD_DII_ARBITER_STATS_EN
    for (int s = 0; s < PORTS; s++) check($sformatf("pkt_count%0d", s), 32'(pkt_count[s]), 32'(m_cnt[s]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
